trng_conditioner: RTL

Post-processing stage downstream of the ring-latch entropy source. It samples the raw `random` bit through a two-flop synchronizer at a fixed sample rate and removes bias with a von Neumann pair extractor. It also runs a repetition-count health test, packs debiased bits into bytes and buffers them in a small first-word-fall-through FIFO with a valid/ready output.

---
 rtl/trng_conditioner.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/trng_conditioner.sv
// TRNG post-processing: synchronizes and samples the raw entropy bit, runs a
// repetition-count health test, von Neumann debiases, packs bytes into a FWFT FIFO.
module trng_conditioner #(
  parameter int SAMPLE_DIV = 8,
  parameter int REP_LIMIT  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          random_in,
  input  logic                          enable,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  output logic                          overrun
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {IDLE, FIRST} vn_state_t;

  logic            s1, s2;
  logic [CW-1:0]   samp_cnt;
  logic            strobe;

  logic            seen;
  logic            last;
  logic [RW-1:0]   run;
  logic [RW-1:0]   run_next;
  logic            trip;
  logic            bits_ok;

  vn_state_t       vn_state;
  logic            first_bit;
  logic            emit_valid;
  logic            emit_bit;

  logic [6:0]      sr;
  logic [2:0]      bit_cnt;
  logic            push;
  logic [7:0]      push_data;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            full;
  logic            pop;
  logic            wr_en;

  // Two-flop synchronizer; random_in is asynchronous to clk.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s1/s2 into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= random_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      samp_cnt <= '0;
    end else if (samp_cnt == CW'(SAMPLE_DIV - 1)) begin
      samp_cnt <= '0;
    end else begin
      samp_cnt <= samp_cnt + 1'b1;
    end
  end

  assign strobe = enable && (samp_cnt == CW'(SAMPLE_DIV - 1));

  // Repetition-count health test; the run counter saturates at the limit.
  // NOTE: every signal driven from always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    run_next = RW'(1);
    if (seen && (s2 == last)) begin
      run_next = (run == RW'(REP_LIMIT)) ? run : run + 1'b1;
    end
  end

  assign trip    = strobe && (run_next == RW'(REP_LIMIT));
  assign bits_ok = !health_fail && !trip;

  always_ff @(posedge clk) begin
    if (reset) begin
      seen        <= 1'b0;
      last        <= 1'b0;
      run         <= '0;
      health_fail <= 1'b0;
    end else if (strobe) begin
      seen <= 1'b1;
      last <= s2;
      run  <= run_next;
      if (trip) begin
        health_fail <= 1'b1;
      end
    end
  end

  // Von Neumann pair extractor: 10 -> 1, 01 -> 0, 00/11 -> nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      vn_state  <= IDLE;
      first_bit <= 1'b0;
    end else if (!enable) begin
      vn_state <= IDLE;
    end else if (strobe) begin
      case (vn_state)
        IDLE: begin
          first_bit <= s2;
          vn_state  <= FIRST;
        end
        FIRST:   vn_state <= IDLE;
        default: vn_state <= IDLE;
      endcase
    end
  end

  assign emit_valid = strobe && (vn_state == FIRST) && (s2 != first_bit) && bits_ok;
  assign emit_bit   = first_bit;

  // Byte assembler; the partial byte survives enable dropping.
  assign push      = emit_valid && (bit_cnt == 3'd7);
  assign push_data = {sr, emit_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (emit_valid) begin
      sr      <= {sr[5:0], emit_bit};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // First-word-fall-through FIFO with binary pointers and an explicit level.
  assign full      = (level == LW'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);

  // NOTE: the storage array is not reset; out_data is forced to zero whenever
  // the FIFO is empty, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && full && !pop) begin
        overrun <= 1'b1;
      end
    end
  end

  assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level = level;

endmodule
